instr_mem_fetch: RTL and testbench

Parametrised, clocked instruction memory with a fetch request/response handshake, programmable wait states, and a load port for writing the program image. It sits between the PC/fetch stage and instruction storage. It replaces unclocked, fixed-depth lookup with byte-addressed, word-aligned fetches. Misaligned and out-of-range fetches are reported as faults and return a NOP.

---
 rtl/instr_mem_fetch.sv | 105 ++++++++++
 tb/tb_instr_mem_fetch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Clocked instruction memory with a fetch request/response handshake,
// programmable wait states, fault reporting and an independent load port.
module instr_mem_fetch #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter int                ADDR_W      = 32,
    parameter int                WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_W-1:0]        instr,
    output logic [1:0]               fault,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]        load_data
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              load_in_range;
    logic              accept;
    logic [DATA_W-1:0] rd_word;

    // The whole byte address is range-checked, so high addresses never alias.
    assign word_idx      = fetch_addr >> OFF_W;
    assign misaligned    = (fetch_addr & ADDR_W'(BYTES - 1)) != '0;
    assign out_of_range  = {1'b0, word_idx} >= (ADDR_W + 1)'(DEPTH);
    assign load_in_range = {1'b0, load_addr} < (IDX_W + 1)'(DEPTH);

    assign fetch_ready = (state == S_IDLE);
    assign instr_valid = (state == S_RESP);
    assign accept      = fetch_req && fetch_ready;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_word = NOP_WORD;
        if (!misaligned && !out_of_range) begin
            rd_word = mem[word_idx[IDX_W-1:0]];
        end
    end

    // NOTE: storage arrays are deliberately not reset; the program image survives rst_n.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[load_addr] <= load_data;
        end
    end

    // NOTE: non-blocking updates mean a load and an accept on the same edge
    // latch the old word (read-before-write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            instr    <= NOP_WORD;
            fault    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        instr    <= rd_word;
                        fault    <= {out_of_range, misaligned};
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (instr_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: one instance with two wait states and a
// second with zero wait states and a non-power-of-two depth.
module tb_instr_mem_fetch;

    localparam int          WS_A = 2;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=16, WAIT_STATES=2
    logic        req_a  = 1'b0;
    logic [31:0] addr_a = '0;
    logic        ready_a;
    logic        valid_a;
    logic        irdy_a = 1'b0;
    logic [31:0] instr_a;
    logic [1:0]  fault_a;
    logic        lden_a = 1'b0;
    logic [3:0]  ladr_a = '0;
    logic [31:0] ldat_a = '0;

    // Instance B: DEPTH=12, WAIT_STATES=0 (load indices 12..15 are out of range)
    logic        req_b  = 1'b0;
    logic [31:0] addr_b = '0;
    logic        ready_b;
    logic        valid_b;
    logic        irdy_b = 1'b1;
    logic [31:0] instr_b;
    logic [1:0]  fault_b;
    logic        lden_b = 1'b0;
    logic [3:0]  ladr_b = '0;
    logic [31:0] ldat_b = '0;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    instr_mem_fetch #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_STATES(WS_A), .NOP_WORD(NOP)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(req_a), .fetch_addr(addr_a), .fetch_ready(ready_a),
        .instr_valid(valid_a), .instr_ready(irdy_a), .instr(instr_a), .fault(fault_a),
        .load_en(lden_a), .load_addr(ladr_a), .load_data(ldat_a)
    );

    instr_mem_fetch #(
        .DATA_W(32), .DEPTH(12), .ADDR_W(32), .WAIT_STATES(0), .NOP_WORD(NOP)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(req_b), .fetch_addr(addr_b), .fetch_ready(ready_b),
        .instr_valid(valid_b), .instr_ready(irdy_b), .instr(instr_b), .fault(fault_b),
        .load_en(lden_b), .load_addr(ladr_b), .load_data(ldat_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_a(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        lden_a = 1'b1; ladr_a = idx; ldat_a = d;
        @(posedge clk);
        #1 lden_a = 1'b0;
    endtask

    task automatic load_b(input logic [3:0] idx, input logic [31:0] d);
        @(negedge clk);
        lden_b = 1'b1; ladr_b = idx; ldat_b = d;
        @(posedge clk);
        #1 lden_b = 1'b0;
    endtask

    // lmode: 0 = no load, 1 = load on the accept edge, 2 = load during WAIT
    task automatic fetch_a(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_i, input logic [1:0] exp_f,
                           input int hold, input int lmode,
                           input logic [3:0] lidx, input logic [31:0] ldat);
        int n;
        @(negedge clk);
        check({tag, ":ready_before"}, ready_a, 1);
        req_a = 1'b1; addr_a = a; irdy_a = (hold == 0);
        if (lmode == 1) begin
            lden_a = 1'b1; ladr_a = lidx; ldat_a = ldat;
        end
        @(posedge clk);
        #1 req_a = 1'b0; lden_a = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            lden_a = (lmode == 2 && n == 0);
            ladr_a = lidx; ldat_a = ldat;
            if (valid_a) break;
        end
        lden_a = 1'b0;
        check({tag, ":latency"}, n + 1, WS_A + 1);
        check({tag, ":instr"}, instr_a, exp_i);
        check({tag, ":fault"}, fault_a, exp_f);
        check({tag, ":ready_busy"}, ready_a, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, ":hold_valid"}, valid_a, 1);
            check({tag, ":hold_instr"}, instr_a, exp_i);
            check({tag, ":hold_ready"}, ready_a, 0);
        end
        irdy_a = 1'b1;
        @(negedge clk);
        check({tag, ":valid_drop"}, valid_a, 0);
        check({tag, ":ready_back"}, ready_a, 1);
    endtask

    task automatic fetch_b(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_i, input logic [1:0] exp_f);
        int n;
        @(negedge clk);
        check({tag, ":ready_before"}, ready_b, 1);
        req_b = 1'b1; addr_b = a;
        @(posedge clk);
        #1 req_b = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (valid_b) break;
        end
        check({tag, ":latency"}, n + 1, 1);
        check({tag, ":instr"}, instr_b, exp_i);
        check({tag, ":fault"}, fault_b, exp_f);
        @(negedge clk);
        check({tag, ":valid_drop"}, valid_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic seen;

        // Reset state
        #12;
        check("rst:ready_a", ready_a, 1);
        check("rst:valid_a", valid_a, 0);
        check("rst:instr_a", instr_a, NOP);
        check("rst:fault_a", fault_a, 0);
        check("rst:ready_b", ready_b, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Program image and basic fetches
        load_a(4'd0, 32'h0000_0000);
        load_a(4'd1, 32'h1111_1111);
        load_a(4'd2, 32'h2222_2222);
        load_a(4'd3, 32'h3333_3333);
        fetch_a("f0", 32'h0, 32'h0000_0000, 2'b00, 0, 0, 4'd0, 32'h0);
        fetch_a("f4", 32'h4, 32'h1111_1111, 2'b00, 0, 0, 4'd0, 32'h0);
        fetch_a("f8", 32'h8, 32'h2222_2222, 2'b00, 0, 0, 4'd0, 32'h0);
        fetch_a("fC", 32'hC, 32'h3333_3333, 2'b00, 0, 0, 4'd0, 32'h0);

        // Backpressure: instr_ready low for 5 cycles
        fetch_a("bp", 32'h4, 32'h1111_1111, 2'b00, 5, 0, 4'd0, 32'h0);

        // Faults, including a high address that must not alias
        fetch_a("mis",   32'h6,         NOP, 2'b01, 0, 0, 4'd0, 32'h0);
        fetch_a("oor",   32'h40,        NOP, 2'b10, 0, 0, 4'd0, 32'h0);
        fetch_a("both",  32'h43,        NOP, 2'b11, 0, 0, 4'd0, 32'h0);
        fetch_a("alias", 32'h8000_0004, NOP, 2'b10, 0, 0, 4'd0, 32'h0);

        // Read-before-write on the accept edge
        fetch_a("rbw_old", 32'h8, 32'h2222_2222, 2'b00, 0, 1, 4'd2, 32'hAAAA_AAAA);
        fetch_a("rbw_new", 32'h8, 32'hAAAA_AAAA, 2'b00, 0, 0, 4'd0, 32'h0);

        // Load to the in-flight word during WAIT leaves the latched response alone
        fetch_a("infl_old", 32'hC, 32'h3333_3333, 2'b00, 0, 2, 4'd3, 32'h5555_5555);
        fetch_a("infl_new", 32'hC, 32'h5555_5555, 2'b00, 0, 0, 4'd0, 32'h0);

        // Reset mid-fetch (during WAIT)
        @(negedge clk);
        req_a = 1'b1; addr_a = 32'h4; irdy_a = 1'b1;
        @(posedge clk);
        #1 req_a = 1'b0;
        check("rstw:busy", ready_a, 0);
        #3 rst_n = 1'b0;
        #1;
        check("rstw:ready", ready_a, 1);
        check("rstw:valid", valid_a, 0);
        check("rstw:instr", instr_a, NOP);
        check("rstw:fault", fault_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen = seen | valid_a;
        end
        check("rstw:no_resp", seen, 0);
        fetch_a("rstw_mem1", 32'h4, 32'h1111_1111, 2'b00, 0, 0, 4'd0, 32'h0);

        // Zero wait states, ignored out-of-range loads
        load_b(4'd0,  32'hDEAD_BEEF);
        load_b(4'd11, 32'h0BAD_F00D);
        load_b(4'd12, 32'hFFFF_FFFF);
        load_b(4'd15, 32'hEEEE_EEEE);
        fetch_b("b_f0",  32'h0,  32'hDEAD_BEEF, 2'b00);
        fetch_b("b_f2C", 32'h2C, 32'h0BAD_F00D, 2'b00);
        fetch_b("b_f30", 32'h30, NOP,           2'b10);
        fetch_b("b_f0b", 32'h0,  32'hDEAD_BEEF, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
